// File: rtl/key_schedule_ctrl_pkg.sv
// Shared definitions for the AES-128 key schedule controller.
//   AES_NR   : number of key expansion steps (round keys 1..10)
//   AES_NK   : key length in 32-bit words
//   RK_IDX_W : width of a round-key index (0..10 fits in 4 bits)
//   round_key_t : one 128-bit round key, word w0 in bits [127:96]
//   ks_state_t  : controller FSM encoding
package key_schedule_ctrl_pkg;

    localparam int AES_NR   = 10;
    localparam int AES_NK   = 4;
    localparam int RK_IDX_W = 4;

    typedef logic [127:0] round_key_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } ks_state_t;

endpackage

// File: rtl/key_schedule_ctrl_key_expansion.sv
// One combinational AES-128 key expansion step.
//   key     : previous round key {w0,w1,w2,w3}
//   count   : step number 0..9, selects the round constant
//   key_out : next round key {w4,w5,w6,w7}
// The S-box is computed arithmetically (GF(2^8) inverse followed by the
// affine transform) rather than stored as a table.
module key_expansion
    import key_schedule_ctrl_pkg::*;
(
    input  logic [127:0]          key,
    input  logic [RK_IDX_W-1:0]   count,
    output logic [127:0]          key_out
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
    // It is accumulated as the product x^2 * x^4 * ... * x^128.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [7:0]  rcon;
    logic [31:0] w3_rot;
    logic [31:0] temp;
    logic [31:0] w4, w5, w6, w7;

    always_comb begin
        rcon = 8'h00;
        case (count)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign w3_rot = {key[23:0], key[31:24]};
    assign temp   = {sbox(w3_rot[31:24]), sbox(w3_rot[23:16]),
                     sbox(w3_rot[15:8]),  sbox(w3_rot[7:0])} ^ {rcon, 24'h000000};
    assign w4      = key[127:96] ^ temp;
    assign w5      = key[95:64]  ^ w4;
    assign w6      = key[63:32]  ^ w5;
    assign w7      = key[31:0]   ^ w6;
    assign key_out = {w4, w5, w6, w7};

endmodule

// File: rtl/key_schedule_ctrl.sv
// Sequential AES-128 key scheduler.
// Loads a cipher key on start, runs one key_expansion step per clock and
// stores round keys 0..10 in an internal register file.
//   clk, rst          : clock, asynchronous active-high reset
//   start, key_in     : load request and cipher key
//   busy              : expansion in progress
//   done              : one-cycle pulse after round key 10 is stored
//   keys_valid        : all 11 round keys stored and stable
//   rk_stream_valid/rk_stream_idx/round_key_stream : key just stored
//   rk_idx, rk_out    : registered read port, 1-cycle latency, 0 for idx>10
//   state_dbg         : current FSM state (0=IDLE, 1=EXPAND)
//
// Handshake: start is a one-cycle request taken only while busy=0; while
// busy=1 it is ignored. The stream has no ready: each asserted
// rk_stream_valid cycle carries one round key that must be taken then.
module key_schedule_ctrl
    import key_schedule_ctrl_pkg::*;
#(
    parameter int NR    = AES_NR,
    parameter int IDX_W = RK_IDX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [127:0]       key_in,
    output logic               busy,
    output logic               done,
    output logic               keys_valid,
    output logic               rk_stream_valid,
    output logic [IDX_W-1:0]   rk_stream_idx,
    output logic [127:0]       round_key_stream,
    input  logic [IDX_W-1:0]   rk_idx,
    output logic [127:0]       rk_out,
    output logic               state_dbg
);

    ks_state_t          state_q, state_d;
    logic [IDX_W-1:0]   cnt_q;
    round_key_t         work_q;
    round_key_t         next_key;
    round_key_t         rk_q [0:NR];
    logic               load;
    logic               step;
    logic               last_step;

    key_expansion u_key_expansion (
        .key     (work_q),
        .count   (cnt_q),
        .key_out (next_key)
    );

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        step      = 1'b0;
        last_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                step = 1'b1;
                if (cnt_q == IDX_W'(NR - 1)) begin
                    last_step = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q == ST_EXPAND);
    assign state_dbg = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            work_q           <= '0;
            for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
            done             <= 1'b0;
            keys_valid       <= 1'b0;
            rk_stream_valid  <= 1'b0;
            rk_stream_idx    <= '0;
            round_key_stream <= '0;
            rk_out           <= '0;
        end else begin
            state_q <= state_d;
            done    <= last_step;
            if (load) begin
                rk_q[0]          <= key_in;
                work_q           <= key_in;
                cnt_q            <= '0;
                keys_valid       <= 1'b0;
                rk_stream_valid  <= 1'b1;
                rk_stream_idx    <= '0;
                round_key_stream <= key_in;
            end else if (step) begin
                rk_q[cnt_q + 1'b1] <= next_key;
                work_q             <= next_key;
                // Counter wraps to 0 after the last step so the expansion
                // input never sees a count above NR-1.
                cnt_q              <= last_step ? '0 : cnt_q + 1'b1;
                rk_stream_valid    <= 1'b1;
                rk_stream_idx      <= cnt_q + 1'b1;
                round_key_stream   <= next_key;
                if (last_step) keys_valid <= 1'b1;
            end else begin
                rk_stream_valid <= 1'b0;
            end
            if (rk_idx <= IDX_W'(NR)) rk_out <= rk_q[rk_idx];
            else                      rk_out <= '0;
        end
    end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
module tb_key_schedule_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic         rk_stream_valid;
    logic [3:0]   rk_stream_idx;
    logic [127:0] round_key_stream;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         state_dbg;

    key_schedule_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .key_in           (key_in),
        .busy             (busy),
        .done             (done),
        .keys_valid       (keys_valid),
        .rk_stream_valid  (rk_stream_valid),
        .rk_stream_idx    (rk_stream_idx),
        .round_key_stream (round_key_stream),
        .rk_idx           (rk_idx),
        .rk_out           (rk_out),
        .state_dbg        (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int           n_checks = 0;
    int           n_bad    = 0;
    int           done_count = 0;
    logic [127:0] exp_q [$];
    logic [3:0]   idx_q [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]   sbox_t [256];
    logic [127:0] mk [11];

    function automatic logic [7:0] m_xtime(input logic [7:0] a);
        return (a[7]) ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = m_xtime(x);
        end
        return r;
    endfunction

    // Inverse by exhaustive search, then the bitwise affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                     ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            sbox_t[x] = s;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // FIPS-197 word-oriented key expansion into mk[0..10].
    task automatic model_keys(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = m_xtime(rc);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) mk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    // ---------------- stream monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_count++;
            if (rk_stream_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_bad++;
                    $display("FAIL stream_unexpected: got idx %0d data %h expected no stream", rk_stream_idx, round_key_stream);
                end else begin
                    logic [127:0] e;
                    logic [3:0]   ei;
                    e  = exp_q.pop_front();
                    ei = idx_q.pop_front();
                    check("stream_idx", 128'(rk_stream_idx), 128'(ei));
                    check("stream_data", round_key_stream, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_key(input logic [127:0] k, input bit accepted);
        if (accepted) begin
            model_keys(k);
            for (int r = 0; r < 11; r++) begin
                exp_q.push_back(mk[r]);
                idx_q.push_back(4'(r));
            end
        end
        start  = 1'b1;
        key_in = k;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 30 && !seen) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) seen = 1'b1;
        end
        check("done_latency", 128'(cyc), 128'(exp_cyc));
    endtask

    task automatic read_rk(input logic [3:0] i, output logic [127:0] d);
        rk_idx = i;
        @(posedge clk);
        #1;
        d = rk_out;
    endtask

    task automatic check_all_keys(input string name);
        logic [127:0] d;
        for (int r = 0; r < 11; r++) begin
            read_rk(4'(r), d);
            check(name, d, mk[r]);
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [127:0] key;
        logic [127:0] rk1;
        logic [127:0] rk10;
    } vec_t;

    vec_t vecs [2];

    initial begin
        logic [127:0] d;
        logic [127:0] ka;
        logic [127:0] kb;
        int           d0;

        vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'ha0fafe1788542cb123a339392a6c7605,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{128'h0,
                    128'h62636363626363636263636362636363,
                    128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        rst    = 1'b1;
        start  = 1'b0;
        key_in = '0;
        rk_idx = '0;
        build_sbox();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_busy", 128'(busy), 128'(0));
        check("idle_keys_valid", 128'(keys_valid), 128'(0));

        // Known-answer vectors
        for (int v = 0; v < 2; v++) begin
            start_key(vecs[v].key, 1'b1);
            check("busy_after_start", 128'(busy), 128'(1));
            check("kv_after_start", 128'(keys_valid), 128'(0));
            wait_done(10);
            check("kv_at_done", 128'(keys_valid), 128'(1));
            check("busy_at_done", 128'(busy), 128'(0));
            @(posedge clk);
            #1;
            check("done_one_cycle", 128'(done), 128'(0));
            read_rk(4'd1, d);
            check("kat_rk1", d, vecs[v].rk1);
            read_rk(4'd10, d);
            check("kat_rk10", d, vecs[v].rk10);
            read_rk(4'd0, d);
            check("kat_rk0", d, vecs[v].key);
        end

        // Mid-cycle asynchronous reset with keys loaded
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_keys_valid", 128'(keys_valid), 128'(0));
        check("rst_stream_valid", 128'(rk_stream_valid), 128'(0));
        check("rst_stream_idx", 128'(rk_stream_idx), 128'(0));
        check("rst_stream_data", round_key_stream, 128'(0));
        check("rst_rk_out", rk_out, 128'(0));
        exp_q.delete();
        idx_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            read_rk(4'(i), d);
            check("rst_read", d, 128'(0));
        end

        // Random keys against the model, plus out-of-range reads
        for (int n = 0; n < 3; n++) begin
            ka = {$urandom, $urandom, $urandom, $urandom};
            start_key(ka, 1'b1);
            wait_done(10);
            check_all_keys("rand_rk");
            for (int i = 11; i < 16; i++) begin
                read_rk(4'(i), d);
                check("oob_read", d, 128'(0));
            end
        end

        // Start while busy is ignored
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = ~ka;
        d0 = done_count;
        start_key(ka, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        start_key(kb, 1'b0);
        wait_done(6);
        @(posedge clk);
        #1;
        check("busy_start_done_pulses", 128'(done_count - d0), 128'(1));
        check_all_keys("busy_start_rk");

        // Reset abort mid-expansion, then a fresh key
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        start_key(ka, 1'b1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", 128'(busy), 128'(0));
        exp_q.delete();
        idx_q.delete();
        d0 = done_count;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        check("abort_no_stale_done", 128'(done_count - d0), 128'(0));
        check("abort_kv", 128'(keys_valid), 128'(0));
        start_key(kb, 1'b1);
        wait_done(10);
        check_all_keys("abort_new_rk");

        // Back-to-back start the cycle after done
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        start_key(ka, 1'b1);
        wait_done(10);
        start_key(kb, 1'b1);
        check("b2b_kv_falls", 128'(keys_valid), 128'(0));
        check("b2b_busy", 128'(busy), 128'(1));
        wait_done(10);
        check("b2b_kv", 128'(keys_valid), 128'(1));
        check_all_keys("b2b_rk");

        repeat (2) @(posedge clk);
        #1;
        check("stream_leftover", 128'(exp_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
